dmem_responder: RTL

//  Memory-side responder for the core's load/store data path. It accepts one

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a word RAM, RV32I byte/half/word with sign/zero extension.
// Latency: response valid WAIT_CYCLES+1 edges after accept; holds the response until rsp_ready, no new request until then.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    req_t        req_q;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [1:0]    lane;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          acc_err;
    logic [31:0]   ld_data;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          access;

    always_comb begin
        off      = req_q.addr - BASE_ADDR;
        lane     = off[1:0];
        word_idx = off[AW+1:2];
        rd_word  = mem[word_idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = off[1] ? rd_word[31:16] : rd_word[15:0];
        access   = (state == WAIT) && (cnt == 4'd0);

        acc_err = 1'b0;
        if (req_q.addr < BASE_ADDR || off[31:2] >= 30'(DEPTH_WORDS))
            acc_err = 1'b1;
        case (req_q.funct3[1:0])
            2'b01:   if (lane[0]) acc_err = 1'b1;
            2'b10:   if (lane != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
        // BU/HU are load-only encodings; 110 is illegal for both directions
        if (req_q.we && req_q.funct3[2])
            acc_err = 1'b1;
        if (!req_q.we && req_q.funct3 == 3'b110)
            acc_err = 1'b1;

        case (req_q.funct3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_data = {24'h0, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_data = {16'h0, rd_half};
            3'b010:  ld_data = rd_word;
            default: ld_data = 32'h0;
        endcase

        case (req_q.funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_q.wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_q.wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_q.wdata;
            end
        endcase
    end

    // State resets asynchronously to IDLE, so a reset during WAIT can never reach the write below
    always_ff @(posedge clk) begin
        if (access && req_q.we && !acc_err) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i])
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q     <= '{we: req_we, addr: req_addr, funct3: req_funct3, wdata: req_wdata};
                        cnt       <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || req_q.we) ? 32'h0 : ld_data;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
